// File: rtl/inner_product.sv
// inner_product: fixed-point inner product of N unsigned arguments with N
// trainable signed weights plus a bias, L multipliers per beat (B = N/L beats).
// With train set at the result handshake it takes an error term, emits
// per-input back-propagated errors and updates weights and bias.
// All arithmetic saturates to the destination width; nothing wraps.
//
// Ports:
//   clock, reset        clock; synchronous active-high reset
//   train               sampled at the result handshake, selects the training path
//   argument_*          N x W unsigned arguments in (ready only in IDLE)
//   result_*            saturated signed 2W inner product out
//   error_*             signed 2W delta in (ready only in DEL)
//   propagate_*         N x 2W signed back-propagated errors out
module inner_product #(
   parameter int unsigned N = 2,
   parameter int unsigned L = 1,
   parameter int unsigned W = 8,
   parameter int unsigned F = W,
   parameter int unsigned S = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 train,
   input  logic                 argument_valid,
   input  logic [N*W-1:0]       argument_data,
   output logic                 argument_ready,
   output logic                 result_valid,
   output logic [2*W-1:0]       result_data,
   input  logic                 result_ready,
   input  logic                 error_valid,
   input  logic [2*W-1:0]       error_data,
   output logic                 error_ready,
   output logic                 propagate_valid,
   output logic [N*2*W-1:0]     propagate_data,
   input  logic                 propagate_ready
);

   localparam int unsigned B  = N / L;
   localparam int unsigned WW = 2 * W;
   localparam int unsigned AW = 2 * W + $clog2(N) + 2;
   // Wide enough for weight*delta (4W) plus any accumulator sum without wrap.
   localparam int unsigned XW = 4 * W + $clog2(N) + 4;
   localparam int unsigned CW = (B > 1) ? $clog2(B) : 1;
   localparam int unsigned NW = (N > 1) ? $clog2(N) : 1;

   localparam logic signed [XW-1:0] WW_MAX = {{(XW-WW+1){1'b0}}, {(WW-1){1'b1}}};
   localparam logic signed [XW-1:0] WW_MIN = {{(XW-WW+1){1'b1}}, {(WW-1){1'b0}}};
   localparam logic signed [XW-1:0] AW_MAX = {{(XW-AW+1){1'b0}}, {(AW-1){1'b1}}};
   localparam logic signed [XW-1:0] AW_MIN = {{(XW-AW+1){1'b1}}, {(AW-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE, MAC, ACC, RES, DEL, ERR, PRP, UPD
   } state_t;

   // Clamp a wide signed value to the signed 2W range.
   function automatic logic signed [WW-1:0] sat_ww(input logic signed [XW-1:0] x);
      if (x > WW_MAX) return WW_MAX[WW-1:0];
      if (x < WW_MIN) return WW_MIN[WW-1:0];
      return x[WW-1:0];
   endfunction

   // Clamp a wide signed value to the accumulator range.
   function automatic logic signed [AW-1:0] sat_aw(input logic signed [XW-1:0] x);
      if (x > AW_MAX) return AW_MAX[AW-1:0];
      if (x < AW_MIN) return AW_MIN[AW-1:0];
      return x[AW-1:0];
   endfunction

   // Input index handled by a given lane during a given beat.
   function automatic logic [NW-1:0] lane_idx(input logic [CW-1:0] beat, input int unsigned lane);
      return NW'(32'(beat) * L + lane);
   endfunction

   state_t                  state;
   state_t                  state_next;
   logic [CW-1:0]           cnt;
   logic                    last_beat;

   logic signed [W:0]       arg    [N];
   logic signed [WW-1:0]    weight [N];
   logic signed [WW-1:0]    err    [N];
   logic signed [WW-1:0]    bias;
   logic signed [WW-1:0]    delta;
   logic signed [AW-1:0]    acc;
   logic signed [AW-1:0]    psum;

   logic signed [XW-1:0]    lane_sum;
   logic signed [WW-1:0]    lane_err [L];
   logic signed [WW-1:0]    lane_wt  [L];

   assign last_beat = (cnt == CW'(B - 1));

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next state and combinational readies.
   always_comb begin
      state_next     = state;
      argument_ready = 1'b0;
      error_ready    = 1'b0;
      case (state)
         IDLE: begin
            argument_ready = 1'b1;
            if (argument_valid) state_next = MAC;
         end
         MAC: if (last_beat) state_next = ACC;
         ACC: state_next = RES;
         RES: if (result_valid && result_ready) state_next = train ? DEL : IDLE;
         DEL: begin
            error_ready = 1'b1;
            if (error_valid) state_next = ERR;
         end
         ERR: if (last_beat) state_next = PRP;
         PRP: if (propagate_valid && propagate_ready) state_next = UPD;
         UPD: if (last_beat) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Per-beat lane arithmetic: partial product sum, weighted errors, weight updates.
   always_comb begin
      lane_sum = '0;
      lane_err = '{default: '0};
      lane_wt  = '{default: '0};
      for (int unsigned l = 0; l < L; l++) begin
         lane_sum = lane_sum
                  + ((XW'(weight[lane_idx(cnt, l)]) * XW'(arg[lane_idx(cnt, l)])) >>> F);
         lane_err[l] = sat_ww((XW'(weight[lane_idx(cnt, l)]) * XW'(delta)) >>> F);
         lane_wt[l]  = sat_ww(XW'(weight[lane_idx(cnt, l)])
                            + ((XW'(delta) * XW'(arg[lane_idx(cnt, l)])) >>> (S + F)));
      end
   end

   // Datapath registers, beat counter and registered valids.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt             <= '0;
         bias            <= '0;
         delta           <= '0;
         acc             <= '0;
         psum            <= '0;
         result_valid    <= 1'b0;
         result_data     <= '0;
         propagate_valid <= 1'b0;
         for (int unsigned n = 0; n < N; n++) begin
            arg[n]    <= '0;
            weight[n] <= '0;
            err[n]    <= '0;
         end
      end else begin
         // Valids rise one edge after entering the output state and drop on handshake.
         result_valid    <= (state == RES) && !(result_valid && result_ready);
         propagate_valid <= (state == PRP) && !(propagate_valid && propagate_ready);

         if ((state == MAC) || (state == ERR) || (state == UPD))
            cnt <= last_beat ? '0 : cnt + 1'b1;

         case (state)
            IDLE: begin
               if (argument_valid) begin
                  for (int unsigned n = 0; n < N; n++)
                     arg[n] <= {1'b0, argument_data[n*W +: W]};
               end
            end
            MAC: begin
               psum <= sat_aw(lane_sum);
               // Beat 0 seeds the accumulator with the bias; later beats add the previous partial.
               acc  <= (cnt == '0) ? AW'(bias) : sat_aw(XW'(acc) + XW'(psum));
            end
            ACC: acc <= sat_aw(XW'(acc) + XW'(psum));
            RES: begin
               if (!result_valid) result_data <= sat_ww(XW'(acc));
            end
            DEL: begin
               if (error_valid) begin
                  delta <= $signed(error_data);
                  bias  <= sat_ww(XW'(bias) + (XW'($signed(error_data)) >>> S));
               end
            end
            ERR: begin
               for (int unsigned l = 0; l < L; l++)
                  err[lane_idx(cnt, l)] <= lane_err[l];
            end
            UPD: begin
               for (int unsigned l = 0; l < L; l++)
                  weight[lane_idx(cnt, l)] <= lane_wt[l];
            end
            default: ;
         endcase
      end
   end

   // Pack the registered per-input errors onto the output bus.
   for (genvar n = 0; n < N; n++) begin : g_pack
      assign propagate_data[n*WW +: WW] = err[n];
   end

endmodule

// File: tb/tb_inner_product.sv
// Bench for inner_product: three instances (L=2, L=1, L=4; N=4, W=8, F=8, S=2)
// exercised one at a time against a behavioural model and a result scoreboard.
module tb_inner_product;

   localparam int unsigned NI = 3;

   logic        clock = 1'b0;
   logic        reset;
   logic        tr [NI];
   logic        av [NI];
   logic        ar [NI];
   logic        rv [NI];
   logic        rr [NI];
   logic        ev [NI];
   logic        er [NI];
   logic        pv [NI];
   logic        pr [NI];
   logic [31:0] ad [NI];
   logic [15:0] rd [NI];
   logic [15:0] ed [NI];
   logic [63:0] pd [NI];

   always #5 clock = ~clock;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      inner_product #(
         .N(4), .L(g == 0 ? 2 : (g == 1 ? 1 : 4)), .W(8), .F(8), .S(2)
      ) u_dut (
         .clock           (clock),
         .reset           (reset),
         .train           (tr[g]),
         .argument_valid  (av[g]),
         .argument_data   (ad[g]),
         .argument_ready  (ar[g]),
         .result_valid    (rv[g]),
         .result_data     (rd[g]),
         .result_ready    (rr[g]),
         .error_valid     (ev[g]),
         .error_data      (ed[g]),
         .error_ready     (er[g]),
         .propagate_valid (pv[g]),
         .propagate_data  (pd[g]),
         .propagate_ready (pr[g])
      );
   end

   int     vectors;
   int     miscompares;
   int     cur_k;
   longint exp_q [$];
   longint wm [4];
   longint am [4];
   longint bm;
   longint last_result;

   task automatic check_eq(input string tag, input longint got, input longint want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s (inst %0d): got %0d expected %0d", tag, cur_k, got, want);
      end
   endtask

   function automatic longint sat16(input longint x);
      if (x > 32767)  return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   function automatic int beats(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 4 : 1);
   endfunction

   function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   task automatic model_reset();
      bm = 0;
      for (int n = 0; n < 4; n++) begin
         wm[n] = 0;
         am[n] = 0;
      end
   endtask

   function automatic longint model_result(input logic [31:0] args);
      longint s = bm;
      for (int n = 0; n < 4; n++)
         s += (wm[n] * longint'(args[n*8 +: 8])) >>> 8;
      return sat16(s);
   endfunction

   // Reset everything; ends at a negedge with reset released.
   task automatic reset_dut(input int k);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tr[i] = 1'b0; av[i] = 1'b0; rr[i] = 1'b0; ev[i] = 1'b0; pr[i] = 1'b0;
         ad[i] = '0;   ed[i] = '0;
      end
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      check_eq("rst_result_valid", longint'(rv[k]), 0);
      check_eq("rst_propagate_valid", longint'(pv[k]), 0);
      check_eq("rst_result_data", longint'(rd[k]), 0);
      check_eq("rst_propagate_data", longint'(pd[k]), 0);
      check_eq("rst_argument_ready", longint'(ar[k]), 1);
      check_eq("rst_error_ready", longint'(er[k]), 0);
      reset = 1'b0;
      model_reset();
   endtask

   // One inference pass; starts and ends at a negedge.
   task automatic infer(input int k, input logic [31:0] args, input logic trn, input int hold);
      int          lat;
      logic [15:0] held;
      exp_q.push_back(model_result(args));
      for (int n = 0; n < 4; n++) am[n] = longint'(args[n*8 +: 8]);
      check_eq("argument_ready_idle", longint'(ar[k]), 1);
      av[k] = 1'b1;
      ad[k] = args;
      @(posedge clock);
      @(negedge clock);
      av[k] = 1'b0;
      lat = 0;
      while (!rv[k] && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      check_eq("result_latency", lat, beats(k) + 2);
      held = rd[k];
      if (hold > 0) begin
         av[k] = 1'b1;
         ad[k] = ~args;
         for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            @(negedge clock);
            check_eq("hold_result_valid", longint'(rv[k]), 1);
            check_eq("hold_result_data", longint'(rd[k]), longint'(held));
            check_eq("hold_argument_ready", longint'(ar[k]), 0);
         end
         av[k] = 1'b0;
      end
      last_result = longint'($signed(rd[k]));
      check_eq("result_data", last_result, exp_q.pop_front());
      rr[k] = 1'b1;
      tr[k] = trn;
      @(posedge clock);
      @(negedge clock);
      rr[k] = 1'b0;
      tr[k] = ~trn;
      check_eq("result_valid_drop", longint'(rv[k]), 0);
      check_eq("ready_after_result", longint'(ar[k]), longint'(!trn));
      check_eq("error_ready_after_result", longint'(er[k]), longint'(trn));
      tr[k] = 1'b0;
   endtask

   // One training step from DEL; starts and ends at a negedge.
   task automatic train_step(input int k, input int d);
      int lat;
      for (int n = 0; n < 4; n++)
         exp_q.push_back(sat16((wm[n] * longint'(d)) >>> 8));
      check_eq("error_ready_del", longint'(er[k]), 1);
      ev[k] = 1'b1;
      ed[k] = 16'(d);
      @(posedge clock);
      @(negedge clock);
      ev[k] = 1'b0;
      lat = 0;
      while (!pv[k] && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      check_eq("propagate_latency", lat, beats(k) + 1);
      for (int n = 0; n < 4; n++)
         check_eq("propagate_data", longint'($signed(pd[k][n*16 +: 16])), exp_q.pop_front());
      bm = sat16(bm + (longint'(d) >>> 2));
      for (int n = 0; n < 4; n++)
         wm[n] = sat16(wm[n] + ((longint'(d) * am[n]) >>> 10));
      pr[k] = 1'b1;
      @(posedge clock);
      @(negedge clock);
      pr[k] = 1'b0;
      check_eq("propagate_valid_drop", longint'(pv[k]), 0);
      lat = 0;
      while (!ar[k] && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      check_eq("update_latency", lat, beats(k));
   endtask

   initial begin
      logic [31:0] base;
      vectors     = 0;
      miscompares = 0;
      base        = pack4(10, 20, 30, 40);

      for (int k = 0; k < 3; k++) begin
         cur_k = k;
         reset_dut(k);
         infer(k, base, 1'b0, (k == 0) ? 5 : 0);
         check_eq("plan_first_result", last_result, 0);
         infer(k, base, 1'b1, 0);
         train_step(k, 256);
         infer(k, base, 1'b0, 0);
         check_eq("plan_trained_result", last_result, 65);
         infer(k, base, 1'b1, 0);
         train_step(k, -5000);
         for (int i = 0; i < 3; i++) begin
            infer(k, pack4(int'($urandom_range(255)), int'($urandom_range(255)),
                           int'($urandom_range(255)), int'($urandom_range(255))), 1'b1, 0);
            train_step(k, int'($urandom_range(40000)) - 20000);
         end
         infer(k, pack4(int'($urandom_range(255)), int'($urandom_range(255)),
                        int'($urandom_range(255)), int'($urandom_range(255))), 1'b0, 0);
      end

      // Bias saturation over repeated large deltas with zero arguments.
      cur_k = 0;
      reset_dut(0);
      for (int i = 0; i < 5; i++) begin
         infer(0, 32'h0, 1'b1, 0);
         train_step(0, 32767);
      end
      infer(0, 32'h0, 1'b0, 0);
      check_eq("bias_clamp", last_result, 32767);
      infer(0, base, 1'b0, 0);
      check_eq("weights_unchanged", last_result, 32767);

      // Reset while in ERR discards the training step.
      reset_dut(0);
      infer(0, base, 1'b1, 0);
      train_step(0, 256);
      infer(0, base, 1'b1, 0);
      ev[0] = 1'b1;
      ed[0] = 16'd256;
      @(posedge clock);
      @(negedge clock);
      ev[0] = 1'b0;
      check_eq("error_ready_in_err", longint'(er[0]), 0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check_eq("err_reset_result_valid", longint'(rv[0]), 0);
      check_eq("err_reset_propagate_valid", longint'(pv[0]), 0);
      check_eq("err_reset_idle", longint'(ar[0]), 1);
      reset = 1'b0;
      model_reset();
      infer(0, pack4(40, 40, 40, 40), 1'b0, 0);
      check_eq("post_reset_result", last_result, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/inner_product.md
# inner_product

Parametrised, lane-parallel successor to the single-multiplier neuron dot-product unit. It computes a fixed-point inner product of N unsigned arguments with N trainable signed weights plus a bias, using L multipliers per cycle. When `train` is set, it accepts an error term, back-propagates weighted errors and updates weights and bias with a shift-based learning rate. All internal arithmetic saturates. It is the per-neuron compute element in the layer fabric, between the activation stage and the previous layer's error path.

## Interface
- `N`, 2: number of inputs/weights.
- `L`, 1: parallel lanes; N must be a multiple of L; beats B = N/L.
- `W`, 8: argument width (unsigned); result/error/weight width is 2W (signed).
- `F`, W: fraction bits in weights, errors and results.
- `S`, 2: learning-rate shift.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `train`  in  1  sampled at result handshake; 1 enters the training path.
- `argument_valid`  in  1  argument handshake.
- `argument_data`  in  N×W  arguments.
- `argument_ready`  out  1  high only in IDLE.
- `result_valid`  out  1  result handshake.
- `result_data`  out  2W  saturated inner product.
- `result_ready`  in  1.
- `error_valid`  in  1  error handshake.
- `error_data`  in  2W  signed delta.
- `error_ready`  out  1  high only in DEL.
- `propagate_valid`  out  1  back-propagated error handshake.
- `propagate_data`  out  N×2W  per-input errors.
- `propagate_ready`  in  1.

## Operation
- States: IDLE, MAC, ACC, RES, DEL, ERR, PRP, UPD.
- IDLE→MAC on argument handshake; arguments are registered and zero-extended to W+1 signed.
- MAC: B beats. Beat b forms lanes n = bL..bL+L-1, p[n] = (weight[n]·arg[n]) >>> F (arithmetic), and registers their sum. The accumulator (width 2W+clog2(N)+2) starts at bias.
- ACC: one cycle that adds the last partial sum. → RES.
- RES: result_valid holds the accumulator saturated to signed 2W. On handshake: →DEL if train, else →IDLE.
- DEL: on error handshake, delta is latched; bias ← sat2W(bias + (delta >>> S)). → ERR.
- ERR: B beats. err[n] = sat2W((weight[n]·delta) >>> F), using pre-update weights. → PRP.
- PRP: propagate_valid with all N errors; on handshake → UPD.
- UPD: B beats, L weights per beat. weight[n] ← sat2W(weight[n] + ((delta·arg[n]) >>> (S+F))). → IDLE.
- Saturation clamps to [−2^(2W−1), 2^(2W−1)−1]; there is no wrap anywhere.

## Timing
- Reset values: state IDLE, beat counter 0, all weights 0, bias 0, accumulator 0, result_valid 0, propagate_valid 0, result_data 0, propagate_data 0.
- argument_ready and error_ready are combinational from state. result_valid and propagate_valid are registered.
- result_valid rises exactly B+2 edges after the argument handshake edge.
- propagate_valid rises B+1 edges after the error handshake edge.
- argument_ready returns B edges after the propagate handshake, or 1 edge after the result handshake when train=0.
- Valid outputs hold value and data stable until ready; handshake when valid and ready are both high at an edge.
- argument_valid outside IDLE and error_valid outside DEL are ignored.
- train is sampled only at the result handshake edge. Changes at other times have no effect.
- reset in any state takes effect next edge: drops valids, returns to IDLE, and clears weights and bias (the training mid-update is discarded).
- Beat counter wraps from B−1 to 0 on leaving MAC, ERR and UPD. With B=1, each of these states lasts one cycle.

## Test plan
- N=4, L=2, W=8, F=8, S=2, after reset, args [10,20,30,40], train=0 → result 0, 4 edges after accept; argument_ready high 1 edge after result handshake; error_ready never high.
- Same config, train=1, error 256 → propagate [0,0,0,0]; then bias=64 and weights=[2,5,7,10]. Re-present [10,20,30,40] → result 65.
- Hold result_ready low 5 cycles → result_valid stays 1, result_data stable, argument_ready 0 and new argument_valid ignored.
- Five training passes with args all 0, error 32767 → bias clamps at 32767 (no wrap), weights unchanged, next result 32767.
- Repeat the first two cases with L=1 and with L=4 → identical data; latency to result 6 and 3 edges respectively.
- Assert reset during ERR after one training delta → valids 0, state IDLE, next all-args-40 pass returns result 0.
